// File: rtl/stonyman_adc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : stonyman_adc_capture
//  Purpose  : Drives NCH serial pixel ADCs over a shared CS/SCLK. Each frame
//             collects 16 bits per channel, MSB first, and tags each sample
//             with its channel number. The tagged words are pushed into a
//             first-word-fall-through FIFO that has a sticky overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module stonyman_adc_capture #(
    parameter int NCH        = 3,
    parameter int ADC_BITS   = 12,
    parameter int SCLK_DIV   = 4,
    parameter int QUIET_CYC  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          PCLK,
    input  logic                          PRESETN,
    input  logic                          start,
    input  logic                          mode_cont,
    input  logic                          clr_ovf,
    input  logic [NCH-1:0]                adc_din,
    output logic                          CS,
    output logic                          SCLK,
    output logic                          busy,
    output logic                          conv_complete,
    input  logic                          rd_en,
    output logic [15:0]                   rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int c_HALF     = SCLK_DIV / 2;
    localparam int c_CONV_CYC = 16 * SCLK_DIV;
    localparam int c_CNT_MAX  = (c_CONV_CYC > QUIET_CYC) ? c_CONV_CYC : QUIET_CYC;
    localparam int c_CW       = $clog2(c_CNT_MAX) + 1;
    localparam int c_HW       = $clog2(c_HALF) + 1;
    localparam int c_AW       = $clog2(FIFO_DEPTH);
    localparam int c_LW       = c_AW + 1;
    localparam logic [15:0] c_MASK = 16'((32'h1 << ADC_BITS) - 32'h1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_WRITE = 2'd2,
        S_QUIET = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_HW-1:0]   r_half;
    logic [1:0]        r_wcnt;
    logic              r_cs;
    logic              r_sclk;
    logic              r_cc;
    logic [15:0]       r_shift [NCH];

    logic [15:0]       r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_LW-1:0]   r_level;
    logic              r_ovf;

    logic              w_rise;
    logic              w_push;
    logic [15:0]       w_frame;
    logic [15:0]       w_wdata;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;
    logic              w_drop;

    // SCLK is about to go high: this is the edge on which data is sampled
    assign w_rise = (r_state == S_CONV) && (r_half == c_HW'(c_HALF - 1)) && !r_sclk;

    // Capture sequencer: frame timing, chip select, serial clock, write slots
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_half  <= '0;
            r_wcnt  <= '0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b1;
            r_cc    <= 1'b0;
        end else begin
            r_cc <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CONV;
                        r_cs    <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_cnt   <= '0;
                        r_half  <= '0;
                    end
                end
                S_CONV: begin
                    if (r_half == c_HW'(c_HALF - 1)) begin
                        r_half <= '0;
                        r_sclk <= ~r_sclk;
                    end else begin
                        r_half <= r_half + c_HW'(1);
                    end
                    if (r_cnt == c_CW'(c_CONV_CYC - 1)) begin
                        r_state <= S_WRITE;
                        r_cs    <= 1'b1;
                        r_sclk  <= 1'b1;
                        r_cc    <= 1'b1;
                        r_wcnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_WRITE: begin
                    if (r_wcnt == 2'(NCH - 1)) begin
                        r_state <= S_QUIET;
                        r_cnt   <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + 2'd1;
                    end
                end
                S_QUIET: begin
                    if (r_cnt == c_CW'(QUIET_CYC - 1)) begin
                        if (mode_cont) begin
                            r_state <= S_CONV;
                            r_cs    <= 1'b0;
                            r_sclk  <= 1'b0;
                            r_cnt   <= '0;
                            r_half  <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Per-channel MSB-first deserialisers, loaded on each SCLK rise
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < NCH; i++) begin
            if (!PRESETN) begin
                r_shift[i] <= '0;
            end else if (w_rise) begin
                r_shift[i] <= {r_shift[i][14:0], adc_din[i]};
            end
        end
    end

    // Select the channel for the current write slot and build the tagged word
    always_comb begin
        w_frame = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_wcnt == 2'(i)) begin
                w_frame = r_shift[i];
            end
        end
        w_wdata = {r_wcnt, 14'b0} | (w_frame & c_MASK);
    end

    assign w_push = (r_state == S_WRITE);
    assign w_full = (r_level == c_LW'(FIFO_DEPTH));
    assign w_pop  = rd_en && (r_level != '0);
    // A pop frees the slot on the same edge, so a full FIFO can still accept
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    // FIFO storage; contents need no reset because level gates visibility
    always_ff @(posedge PCLK) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a drop beats a clear)
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            if (w_wr && !w_pop) begin
                r_level <= r_level + c_LW'(1);
            end else if (!w_wr && w_pop) begin
                r_level <= r_level - c_LW'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign CS            = r_cs;
    assign SCLK          = r_sclk;
    assign busy          = (r_state != S_IDLE);
    assign conv_complete = r_cc;
    assign rd_data       = r_mem[r_rptr];
    assign empty         = (r_level == '0);
    assign full          = w_full;
    assign level         = r_level;
    assign overflow      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stonyman_adc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stonyman_adc_capture
//  Purpose  : Directed bench for stonyman_adc_capture with a serial ADC model
//             and a FIFO scoreboard checked by an independent read monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stonyman_adc_capture;

    localparam int NCH = 3;

    logic             PCLK = 1'b0;
    logic             PRESETN = 1'b0;
    logic             start = 1'b0;
    logic             mode_cont = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             rd_en = 1'b0;
    logic [NCH-1:0]   adc_din = '0;
    logic             CS, SCLK, busy, conv_complete, empty, full, overflow;
    logic [15:0]      rd_data;
    logic [3:0]       level;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    logic [15:0] sb_exp;
    logic [15:0] frm [NCH];

    always #5 PCLK = ~PCLK;

    stonyman_adc_capture #(
        .NCH(NCH), .ADC_BITS(12), .SCLK_DIV(4), .QUIET_CYC(8), .FIFO_DEPTH(8)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .start(start), .mode_cont(mode_cont),
        .clr_ovf(clr_ovf), .adc_din(adc_din), .CS(CS), .SCLK(SCLK), .busy(busy),
        .conv_complete(conv_complete), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .level(level), .overflow(overflow)
    );

    // ADC model: presents bit (15 - rises) of each channel's frame while CS is low
    int   rises = 0;
    logic m_prev_sclk = 1'b1;
    always @(negedge PCLK) begin
        if (CS !== 1'b0) rises = 0;
        else if (SCLK === 1'b1 && m_prev_sclk === 1'b0) rises = rises + 1;
        m_prev_sclk = SCLK;
        for (int c = 0; c < NCH; c++)
            adc_din[c] = (rises < 16) ? frm[c][15 - rises] : 1'b0;
    end

    // Interface statistics
    int   cs_low_cnt = 0, sclk_rise_cnt = 0, cc_cnt = 0, cyc = 0;
    int   cs_rise_cyc = 0, busy_fall_cyc = 0;
    logic s_prev_cs = 1'b1, s_prev_sclk = 1'b1, s_prev_busy = 1'b0;
    always @(negedge PCLK) begin
        cyc = cyc + 1;
        if (CS === 1'b0) cs_low_cnt = cs_low_cnt + 1;
        if (SCLK === 1'b1 && s_prev_sclk === 1'b0) sclk_rise_cnt = sclk_rise_cnt + 1;
        if (conv_complete === 1'b1) cc_cnt = cc_cnt + 1;
        if (CS === 1'b1 && s_prev_cs === 1'b0) cs_rise_cyc = cyc;
        if (busy === 1'b0 && s_prev_busy === 1'b1) busy_fall_cyc = cyc;
        s_prev_cs = CS;
        s_prev_sclk = SCLK;
        s_prev_busy = busy;
    end

    // Scoreboard monitor: every accepted pop is compared against the queue head
    always @(negedge PCLK) begin
        if (rd_en === 1'b1 && empty === 1'b0) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL fifo_pop: got %h, no word expected", rd_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (rd_data !== sb_exp) begin
                    errors = errors + 1;
                    $display("FAIL fifo_pop: got %h expected %h", rd_data, sb_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic timeout(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic wait_cc();
        int n = 0;
        do begin @(negedge PCLK); n++; end while (conv_complete !== 1'b1 && n < 5000);
        if (conv_complete !== 1'b1) timeout("wait_conv_complete");
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge PCLK); n++; end while (busy !== 1'b0 && n < 5000);
        if (busy !== 1'b0) timeout("wait_idle");
    endtask

    task automatic do_start(input logic mc);
        mode_cont = mc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int n);
        tick();
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    task automatic set_frames(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        frm[0] = a;
        frm[1] = b;
        frm[2] = c;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        set_frames(16'h0, 16'h0, 16'h0);

        // Reset state
        repeat (3) tick();
        @(negedge PCLK);
        chk("rst_cs", 32'(CS), 1);
        chk("rst_sclk", 32'(SCLK), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cc", 32'(conv_complete), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        PRESETN = 1'b1;
        tick();

        // Single frame
        set_frames(16'h0ABC, 16'h0123, 16'h0FFF);
        exp_q.push_back(16'h0ABC); exp_q.push_back(16'h4123); exp_q.push_back(16'h8FFF);
        cs_low_cnt = 0; sclk_rise_cnt = 0; cc_cnt = 0;
        do_start(1'b0);
        wait_idle();
        tick();
        chk("single_cs_low", 32'(cs_low_cnt), 64);
        chk("single_sclk_rises", 32'(sclk_rise_cnt), 16);
        chk("single_cc_pulses", 32'(cc_cnt), 1);
        chk("single_busy_fall", 32'(busy_fall_cyc - cs_rise_cyc), 11);
        chk("single_level", 32'(level), 3);
        drain(4);
        @(negedge PCLK);
        chk("underflow_level", 32'(level), 0);
        chk("underflow_empty", 32'(empty), 1);
        chk("single_sb_drained", 32'(exp_q.size()), 0);

        // Upper-bit masking
        set_frames(16'hFABC, 16'h0000, 16'h1234);
        exp_q.push_back(16'h0ABC); exp_q.push_back(16'h4000); exp_q.push_back(16'h8234);
        tick();
        do_start(1'b0);
        wait_idle();
        tick();
        chk("mask_level", 32'(level), 3);
        drain(3);

        // Continuous, no reads: overflow on the third word of frame 3
        set_frames(16'h0111, 16'h0222, 16'h0333);
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(16'h0111); exp_q.push_back(16'h4222); exp_q.push_back(16'h8333);
        end
        exp_q.push_back(16'h0111); exp_q.push_back(16'h4222);
        tick();
        do_start(1'b1);
        wait_cc();
        wait_cc();
        repeat (3) @(negedge PCLK);
        chk("cont_level_2frames", 32'(level), 6);
        chk("cont_ovf_2frames", 32'(overflow), 0);
        wait_cc();
        mode_cont = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("cont_level_full", 32'(level), 8);
        chk("cont_full", 32'(full), 1);
        chk("cont_ovf_set", 32'(overflow), 1);
        wait_idle();
        chk("cont_ovf_sticky", 32'(overflow), 1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge PCLK);
        chk("cont_ovf_clr", 32'(overflow), 0);
        chk("cont_level_after_clr", 32'(level), 8);

        // Full boundary: pop through the whole WRITE phase
        set_frames(16'h0AAA, 16'h0BBB, 16'h0CCC);
        exp_q.push_back(16'h0AAA); exp_q.push_back(16'h4BBB); exp_q.push_back(16'h8CCC);
        tick();
        do_start(1'b0);
        repeat (64) tick();
        rd_en = 1'b1;
        @(negedge PCLK);
        chk("fullrw_cc_timing", 32'(conv_complete), 1);
        chk("fullrw_full_before", 32'(full), 1);
        repeat (3) tick();
        rd_en = 1'b0;
        @(negedge PCLK);
        chk("fullrw_level", 32'(level), 8);
        chk("fullrw_ovf", 32'(overflow), 0);
        wait_idle();
        drain(8);
        @(negedge PCLK);
        chk("fullrw_empty", 32'(empty), 1);
        chk("fullrw_sb_drained", 32'(exp_q.size()), 0);

        // Reset in the middle of frame 2
        set_frames(16'h0555, 16'h0666, 16'h0777);
        tick();
        do_start(1'b1);
        wait_cc();
        repeat (3) @(negedge PCLK);
        chk("rstmid_level_before", 32'(level), 3);
        n = 0;
        do begin tick(); n++; end while (!(CS === 1'b0 && rises >= 9) && n < 5000);
        if (!(CS === 1'b0 && rises >= 9)) timeout("wait_rise9");
        PRESETN = 1'b0;
        tick();
        PRESETN = 1'b1;
        mode_cont = 1'b0;
        exp_q.delete();
        @(negedge PCLK);
        chk("rstmid_cs", 32'(CS), 1);
        chk("rstmid_sclk", 32'(SCLK), 1);
        chk("rstmid_level", 32'(level), 0);
        chk("rstmid_busy", 32'(busy), 0);
        repeat (100) tick();
        chk("rstmid_no_partial", 32'(level), 0);
        set_frames(16'h0135, 16'h0246, 16'h0357);
        exp_q.push_back(16'h0135); exp_q.push_back(16'h4246); exp_q.push_back(16'h8357);
        cs_low_cnt = 0; sclk_rise_cnt = 0;
        do_start(1'b0);
        wait_idle();
        tick();
        chk("rstmid_clean_cs_low", 32'(cs_low_cnt), 64);
        chk("rstmid_clean_rises", 32'(sclk_rise_cnt), 16);
        chk("rstmid_clean_level", 32'(level), 3);
        drain(3);

        // Stop continuous capture during frame 2, with a start while busy
        set_frames(16'h0101, 16'h0202, 16'h0303);
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(16'h0101); exp_q.push_back(16'h4202); exp_q.push_back(16'h8303);
        end
        tick();
        cc_cnt = 0;
        do_start(1'b1);
        wait_cc();
        n = 0;
        do begin @(negedge PCLK); n++; end while (CS !== 1'b0 && n < 1000);
        if (CS !== 1'b0) timeout("wait_frame2_conv");
        mode_cont = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        tick();
        chk("stop_frames", 32'(cc_cnt), 2);
        chk("stop_level", 32'(level), 6);
        repeat (50) tick();
        chk("stop_still_idle", 32'(busy), 0);
        chk("stop_level_after", 32'(level), 6);
        chk("stop_frames_after", 32'(cc_cnt), 2);
        drain(6);
        @(negedge PCLK);
        chk("stop_empty", 32'(empty), 1);
        chk("stop_sb_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
